// File: rtl/uart_tx.sv
// AXI4-Stream to UART serializer.
// Accepts one word per handshake and shifts it out on txd as an async frame:
// start bit, data LSB first, optional parity bit, one or two stop bits.
// Each bit lasts 8*prescale clk cycles; prescale, parity sense and stop
// count are captured at the handshake and held for the whole frame.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale,
  input  logic                  parity_odd,
  input  logic                  two_stop
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [3:0] DW = 4'(DATA_WIDTH);

  logic [2:0]            state_q, state_d;
  logic [18:0]           cnt_q, cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [15:0]           presc_q, presc_d;
  logic                  parity_q, parity_d;
  logic                  two_stop_q, two_stop_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  tready_q, tready_d;

  logic [15:0]           presc_in_s;
  logic [18:0]           reload_s;
  logic [18:0]           hs_reload_s;

  // Parity over the data word, inverted for odd parity.
  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // A prescale of zero would give a zero-length bit, so it is promoted to one.
  assign presc_in_s  = (prescale == 16'd0) ? 16'd1 : prescale;
  // Reload for bits after the start bit uses the latched prescale; the start
  // bit is loaded at the handshake and must use the value being latched.
  assign reload_s    = {presc_q, 3'b000} - 19'd1;
  assign hs_reload_s = {presc_in_s, 3'b000} - 19'd1;

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;

  // Next-state logic for the frame sequencer and its registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    presc_d    = presc_q;
    parity_d   = parity_q;
    two_stop_d = two_stop_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    tready_d   = tready_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        txd_d  = 1'b1;
        if (s_axis_tvalid && tready_q) begin
          shift_d    = s_axis_tdata;
          presc_d    = presc_in_s;
          parity_d   = parity_f(s_axis_tdata, parity_odd);
          two_stop_d = two_stop;
          cnt_d      = hs_reload_s;
          state_d    = ST_START;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          tready_d   = 1'b0;
        end else begin
          tready_d = 1'b1;
        end
      end

      ST_START: begin
        if (cnt_q == 19'd0) begin
          state_d   = ST_DATA;
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = DW;
          cnt_d     = reload_s;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      ST_DATA: begin
        if (cnt_q == 19'd0) begin
          cnt_d = reload_s;
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = two_stop_q ? 4'd2 : 4'd1;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      ST_PARITY: begin
        if (cnt_q == 19'd0) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
          cnt_d   = reload_s;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      ST_STOP: begin
        txd_d = 1'b1;
        if (cnt_q == 19'd0) begin
          if (bit_cnt_q == 4'd1) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            tready_d  = 1'b1;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            cnt_d     = reload_s;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 19'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      presc_q    <= 16'd0;
      parity_q   <= 1'b0;
      two_stop_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      presc_q    <= presc_d;
      parity_q   <= parity_d;
      two_stop_q <= two_stop_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      tready_q   <= tready_d;
    end
  end

endmodule
